lcd_frame_arbiter: RTL and testbench
====================================

Name: lcd_frame_arbiter

Overview:
- Shares the two 16-character LCD line buffers (lineA/lineB, 128 bits each, character 0 in bits [7:0]) among three frame sources:
  - base clock/date display;
  - set-mode menu display;
  - transient message overlay, e.g. an alarm banner.
- Sits between the display-formatting logic and the LCD bus controller.
- Loads new frames into the output lines only at frame boundaries signalled by the LCD controller, so a partially written frame never mixes two sources.

Parameters:
- M_FREQ, 1, mclk cycles per second. Use 1/10/100 in simulation and 20000000 on the board.
- MSG_HOLD_S, 3, seconds a message stays visible once it has been committed to the display.

Ports:
- mclk  input  1  main clock
- rst  input  1  synchronous, active-high reset
- base_a  input  128  base frame line A; always valid
- base_b  input  128  base frame line B
- menu_valid  input  1  menu frame requested; level signal
- menu_a  input  128  menu frame line A
- menu_b  input  128  menu frame line B
- msg_req  input  1  one-cycle pulse requesting a transient message
- msg_a  input  128  message line A; sampled only when msg_req is accepted
- msg_b  input  128  message line B
- msg_ack  output  1  one-cycle pulse when a message is accepted
- msg_busy  output  1  high from acceptance until the message expires
- refresh_done  input  1  one-cycle pulse from the LCD controller after the last character of a frame is written
- lineA  output  128  committed line A to the LCD controller
- lineB  output  128  committed line B
- active_src  output  2  committed source: 0 = base, 1 = menu, 2 = message

Behaviour:
- Reset values:
  - lineA = lineB = 16 x 8'h20;
  - active_src = 0, msg_ack = 0, msg_busy = 0;
  - hold counter = 0, shown flag = 0;
  - message buffer = spaces;
  - state = S_SRC.
- States:
  - S_SRC: no message is held.
  - S_MSG_WAIT: message accepted but not yet committed.
  - S_MSG_SHOW: message committed; hold timer running.
- Message acceptance:
  - msg_req is accepted only if msg_busy is 0 in that cycle.
  - On acceptance, msg_a/msg_b are latched into the message buffer, and msg_ack and msg_busy go high on the next edge. Latency is 1 cycle.
  - The state moves to S_MSG_WAIT.
  - msg_req while msg_busy = 1 is ignored: no ack, buffer unchanged.
- Selected source (combinational, each cycle):
  - message buffer if in S_MSG_WAIT or S_MSG_SHOW;
  - otherwise menu if menu_valid = 1;
  - otherwise base.
- Commit:
  - On a cycle with refresh_done = 1, the selected frame and its source code load into lineA, lineB and active_src at that edge.
  - With no refresh_done, the outputs hold, however the sources or menu_valid change.
- Message display and expiry:
  - S_MSG_WAIT + refresh_done: the message is committed; go to S_MSG_SHOW and clear the hold counter.
  - In S_MSG_SHOW the hold counter increments every mclk.
  - When the count reaches M_FREQ*MSG_HOLD_S-1: msg_busy clears next edge, state returns to S_SRC, and the counter clears.
  - The message remains on lineA/lineB until the next refresh_done commits base or menu.
- Counter: width $clog2(M_FREQ*MSG_HOLD_S+1) with a minimum of 1; no wrap is possible because it clears on expiry.
- Simultaneous events:
  - Expiry and msg_req in the same cycle: the request is ignored, since busy is still 1.
  - msg_req accepted while refresh_done is high in the same cycle: the current selection (not the new message) commits; the message waits for the next refresh_done.
  - menu_valid toggling mid-message: no effect until the message expires.
- rst mid-operation overrides everything: the message is dropped, outputs return to spaces and base, and there is no ack.
- msg_ack is strictly a one-cycle pulse.

Optional Feature:
- Macro: LCD_MSG_BLINK_EN.
- Defined:
  - In S_MSG_SHOW a blink phase toggles every M_FREQ/2 mclk cycles (minimum 1), starting visible.
  - A commit during the blank phase loads 16 x 8'h20 into both lines with active_src = 2.
  - The hold timer is unaffected.
  - The blink phase resets to visible on entry to S_MSG_SHOW.
- Undefined: the message is always committed as latched; no blink logic is synthesised.

Test Plan (M_FREQ=4, MSG_HOLD_S=2, hold = 8 cycles):
- Reset, then refresh_done pulse with menu_valid=0 and base_a = "MON,01-01-2024" -> lineA = base_a, active_src=0. Before that pulse: lineA = 16 x 8'h20.
- menu_valid=1 with no refresh_done for 20 cycles -> outputs unchanged; after the next refresh_done -> active_src=1, lines = menu.
- msg_req with msg_a="ALARM" -> msg_ack high exactly 1 cycle after, msg_busy=1. Next refresh_done -> active_src=2. msg_busy falls 8 cycles after that commit. Next refresh_done -> menu restored.
- Second msg_req while msg_busy=1 -> no msg_ack; buffer and displayed text unchanged.
- msg_req and refresh_done in the same cycle -> old source committed; message committed on the following refresh_done.
- rst asserted in S_MSG_SHOW -> next cycle lines = spaces, active_src=0, msg_busy=0. With LCD_MSG_BLINK_EN defined, commits alternate message/blank every 2 cycles.

Source files
------------

// File: rtl/lcd_frame_arbiter.sv
// Arbitrates base, menu and transient-message frames onto the two LCD lines, committing only at frame boundaries.
// Optional blink of the displayed message is enabled with the LCD_MSG_BLINK_EN macro.
module lcd_frame_arbiter #(
    parameter int M_FREQ     = 1,
    parameter int MSG_HOLD_S = 3
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic [127:0] base_a,
    input  logic [127:0] base_b,
    input  logic         menu_valid,
    input  logic [127:0] menu_a,
    input  logic [127:0] menu_b,
    input  logic         msg_req,
    input  logic [127:0] msg_a,
    input  logic [127:0] msg_b,
    output logic         msg_ack,
    output logic         msg_busy,
    input  logic         refresh_done,
    output logic [127:0] lineA,
    output logic [127:0] lineB,
    output logic [1:0]   active_src
);

    localparam logic [127:0] SPACES = {16{8'h20}};
    localparam int HOLD = M_FREQ * MSG_HOLD_S;
    localparam int CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_SRC      = 2'd0,
        S_MSG_WAIT = 2'd1,
        S_MSG_SHOW = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [127:0]   buf_a_q, buf_a_d;
    logic [127:0]   buf_b_q, buf_b_d;
    logic [127:0]   line_a_q, line_a_d;
    logic [127:0]   line_b_q, line_b_d;
    logic [1:0]     src_q, src_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           msg_blank;
    logic [127:0]   sel_a, sel_b;
    logic [1:0]     sel_src;
    logic           accept;

`ifdef LCD_MSG_BLINK_EN
    localparam int BLINK_HALF = (M_FREQ / 2 < 1) ? 1 : M_FREQ / 2;
    localparam int BW = (BLINK_HALF <= 1) ? 1 : $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;

    // Phase restarts visible on every entry to S_MSG_SHOW and idles cleared otherwise.
    always_comb begin
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (state_q == S_MSG_SHOW) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blank_d     = blank_q;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign msg_blank = blank_q;
`else
    assign msg_blank = 1'b0;
`endif

    // Any held message owns the selection, even before it has been committed.
    always_comb begin
        sel_a   = base_a;
        sel_b   = base_b;
        sel_src = 2'd0;
        if (state_q != S_SRC) begin
            sel_a   = msg_blank ? SPACES : buf_a_q;
            sel_b   = msg_blank ? SPACES : buf_b_q;
            sel_src = 2'd2;
        end else if (menu_valid) begin
            sel_a   = menu_a;
            sel_b   = menu_b;
            sel_src = 2'd1;
        end
    end

    assign accept = msg_req && !busy_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        buf_a_d    = buf_a_q;
        buf_b_d    = buf_b_q;
        line_a_d   = line_a_q;
        line_b_d   = line_b_q;
        src_d      = src_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;

        if (refresh_done) begin
            line_a_d = sel_a;
            line_b_d = sel_b;
            src_d    = sel_src;
        end

        case (state_q)
            S_SRC: begin
                if (accept) begin
                    buf_a_d = msg_a;
                    buf_b_d = msg_b;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_MSG_WAIT;
                end
            end
            S_MSG_WAIT: begin
                if (refresh_done) begin
                    state_d    = S_MSG_SHOW;
                    hold_cnt_d = '0;
                end
            end
            S_MSG_SHOW: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    busy_d     = 1'b0;
                    state_d    = S_SRC;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: state_d = S_SRC;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= S_SRC;
            hold_cnt_q <= '0;
            buf_a_q    <= SPACES;
            buf_b_q    <= SPACES;
            line_a_q   <= SPACES;
            line_b_q   <= SPACES;
            src_q      <= 2'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            line_a_q   <= line_a_d;
            line_b_q   <= line_b_d;
            src_q      <= src_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign lineA      = line_a_q;
    assign lineB      = line_b_q;
    assign active_src = src_q;
    assign msg_ack    = ack_q;
    assign msg_busy   = busy_q;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Directed bench for lcd_frame_arbiter with M_FREQ=4, MSG_HOLD_S=2 (8-cycle message hold).
module tb_lcd_frame_arbiter;

    logic         mclk = 1'b0;
    logic         rst;
    logic [127:0] base_a, base_b, menu_a, menu_b, msg_a, msg_b;
    logic         menu_valid, msg_req, refresh_done;
    logic         msg_ack, msg_busy;
    logic [127:0] lineA, lineB;
    logic [1:0]   active_src;

    int checks = 0;
    int errors = 0;

    logic [127:0] sp, t_base_a, t_base_b, t_menu_a, t_menu_b;
    logic [127:0] t_alarm, t_wake, t_other, t_timer;

    lcd_frame_arbiter #(.M_FREQ(4), .MSG_HOLD_S(2)) dut (
        .mclk(mclk), .rst(rst),
        .base_a(base_a), .base_b(base_b),
        .menu_valid(menu_valid), .menu_a(menu_a), .menu_b(menu_b),
        .msg_req(msg_req), .msg_a(msg_a), .msg_b(msg_b),
        .msg_ack(msg_ack), .msg_busy(msg_busy),
        .refresh_done(refresh_done),
        .lineA(lineA), .lineB(lineB), .active_src(active_src)
    );

    always #5 mclk = ~mclk;

    // Character 0 lands in bits [7:0]; unused characters are spaces.
    function automatic logic [127:0] mk(input string s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[i*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return r;
    endfunction

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse_refresh();
        refresh_done = 1'b1;
        step();
        refresh_done = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        sp       = {16{8'h20}};
        t_base_a = mk("MON,01-01-2024");
        t_base_b = mk("12:00:00");
        t_menu_a = mk("SET TIME");
        t_menu_b = mk("> HOUR");
        t_alarm  = mk("ALARM");
        t_wake   = mk("WAKE UP");
        t_other  = mk("OTHER");
        t_timer  = mk("TIMER");

        rst = 1'b1; menu_valid = 1'b0; msg_req = 1'b0; refresh_done = 1'b0;
        base_a = t_base_a; base_b = t_base_b;
        menu_a = t_menu_a; menu_b = t_menu_b;
        msg_a = t_alarm; msg_b = t_wake;
        step(); step();
        chk("rst_lineA", lineA, sp);
        chk("rst_lineB", lineB, sp);
        chk("rst_src", 128'(active_src), 128'd0);
        chk("rst_busy", 128'(msg_busy), 128'd0);
        chk("rst_ack", 128'(msg_ack), 128'd0);

        rst = 1'b0;
        step();
        chk("pre_commit_lineA", lineA, sp);
        pulse_refresh();
        chk("base_lineA", lineA, t_base_a);
        chk("base_lineB", lineB, t_base_b);
        chk("base_src", 128'(active_src), 128'd0);

        menu_valid = 1'b1;
        repeat (20) step();
        chk("hold_lineA", lineA, t_base_a);
        chk("hold_src", 128'(active_src), 128'd0);
        pulse_refresh();
        chk("menu_src", 128'(active_src), 128'd1);
        chk("menu_lineA", lineA, t_menu_a);
        chk("menu_lineB", lineB, t_menu_b);

        msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        chk("acc_ack", 128'(msg_ack), 128'd1);
        chk("acc_busy", 128'(msg_busy), 128'd1);
        chk("acc_src_unchanged", 128'(active_src), 128'd1);
        step();
        chk("ack_one_cycle", 128'(msg_ack), 128'd0);
        chk("busy_stays", 128'(msg_busy), 128'd1);

        msg_a = t_other; msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        chk("busy_req_no_ack", 128'(msg_ack), 128'd0);
        menu_valid = 1'b0;
        step();
        menu_valid = 1'b1;

        pulse_refresh();
        chk("msg_src", 128'(active_src), 128'd2);
        chk("msg_lineA", lineA, t_alarm);
        chk("msg_lineB", lineB, t_wake);
        repeat (7) step();
        chk("busy_before_expiry", 128'(msg_busy), 128'd1);
        msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        chk("busy_at_expiry", 128'(msg_busy), 128'd0);
        chk("expiry_req_no_ack", 128'(msg_ack), 128'd0);
        step();
        chk("expiry_req_ignored", 128'(msg_ack), 128'd0);
        chk("msg_persists_lineA", lineA, t_alarm);
        chk("msg_persists_src", 128'(active_src), 128'd2);
        pulse_refresh();
        chk("menu_restored_src", 128'(active_src), 128'd1);
        chk("menu_restored_lineA", lineA, t_menu_a);

        msg_a = t_timer; msg_req = 1'b1; refresh_done = 1'b1;
        step();
        msg_req = 1'b0; refresh_done = 1'b0;
        chk("simul_old_src", 128'(active_src), 128'd1);
        chk("simul_old_lineA", lineA, t_menu_a);
        chk("simul_ack", 128'(msg_ack), 128'd1);
        pulse_refresh();
        chk("simul_msg_src", 128'(active_src), 128'd2);
        chk("simul_msg_lineA", lineA, t_timer);

        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_lineA", lineA, sp);
        chk("midrst_lineB", lineB, sp);
        chk("midrst_src", 128'(active_src), 128'd0);
        chk("midrst_busy", 128'(msg_busy), 128'd0);
        chk("midrst_ack", 128'(msg_ack), 128'd0);
        menu_valid = 1'b0;
        pulse_refresh();
        chk("post_rst_base_src", 128'(active_src), 128'd0);
        chk("post_rst_base_lineA", lineA, t_base_a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
